// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: loads an operand and shifts it one position per clock
// for a programmable number of steps, with a start/busy/done handshake.
module seq_shifter #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [AMT_W-1:0] cnt_q,   cnt_d;
   logic [1:0]       mode_q,  mode_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      case (m)
         MODE_LSR: r = {1'b0, d[WIDTH-1:1]};
         MODE_ASR: r = {d[WIDTH-1], d[WIDTH-1:1]};
         MODE_LSL: r = {d[WIDTH-2:0], 1'b0};
         MODE_ROR: r = {d[0], d[WIDTH-1:1]};
         default:  r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         // DONE accepts a new request just like IDLE, giving back-to-back operation
         S_IDLE, S_DONE: begin
            if (start) begin
               shreg_d = din;
               cnt_d   = amount;
               mode_d  = mode;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               shreg_d = shift_step(mode_q, shreg_q);
               cnt_d   = cnt_q - AMT_W'(1);
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign dout = shreg_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vector table, handshake corner
// sequences, and randomized operations against a closed-form reference model.
module tb_seq_shifter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] din = 8'h00;
   logic [3:0] amount = 4'h0;
   logic [7:0] dout;
   logic       busy, done;

   logic       start4 = 1'b0;
   logic [1:0] mode4 = 2'b00;
   logic [3:0] din4 = 4'h0;
   logic [3:0] amount4 = 4'h0;
   logic [3:0] dout4;
   logic       busy4, done4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_shifter #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .din(din),
      .amount(amount), .dout(dout), .busy(busy), .done(done)
   );

   seq_shifter #(.WIDTH(4), .AMT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .din(din4),
      .amount(amount4), .dout(dout4), .busy(busy4), .done(done4)
   );

   typedef struct {
      logic [1:0] m;
      logic [7:0] d;
      logic [3:0] a;
      logic [7:0] exp;
   } vec_t;

   // Closed-form result of `amt` single-step shifts, independent of step count.
   function automatic logic [7:0] ref_shift(input logic [1:0] m, input logic [7:0] d,
                                            input int amt);
      logic [15:0] dd;
      logic [7:0]  r;
      case (m)
         2'b00: r = d >> amt;
         2'b01: r = 8'($signed(d) >>> amt);
         2'b10: r = d << amt;
         default: begin
            dd = {d, d} >> (amt % 8);
            r  = dd[7:0];
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap busy=%0b done=%0b expected not both", busy, done);
         end
      end
   end

   // Issue one operation starting at the next falling edge; follows straight on
   // from a done cycle when called immediately after a previous op.
   task automatic do_op(input logic [1:0] m, input logic [7:0] d, input logic [3:0] a,
                        input logic [7:0] exp, input string name);
      int lat;
      @(negedge clk);
      start = 1'b1; mode = m; din = d; amount = a;
      @(posedge clk); #1;
      start = 1'b0;
      mode = 2'($urandom); din = 8'($urandom); amount = 4'($urandom);
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check({name, "_latency"}, lat, a + 1);
      check({name, "_dout"}, {24'd0, dout}, {24'd0, exp});
      $display("op %s mode=%0d din=%02h amt=%0d dout=%02h lat=%0d", name, m, d, a, dout, lat);
   endtask

   vec_t vecs[8];

   initial begin
      int pulses, lat;
      logic [7:0] res;
      logic [1:0] rm;
      logic [7:0] rd;
      logic [3:0] ra;

      vecs[0] = '{2'b01, 8'h96, 4'd3, 8'hF2};
      vecs[1] = '{2'b00, 8'h96, 4'd3, 8'h12};
      vecs[2] = '{2'b10, 8'h96, 4'd1, 8'h2C};
      vecs[3] = '{2'b11, 8'h81, 4'd4, 8'h18};
      vecs[4] = '{2'b11, 8'h81, 4'd9, 8'hC0};
      vecs[5] = '{2'b00, 8'h81, 4'd9, 8'h00};
      vecs[6] = '{2'b01, 8'h81, 4'd15, 8'hFF};
      vecs[7] = '{2'b10, 8'hFF, 4'd12, 8'h00};

      #12;
      check("reset_dout", {24'd0, dout}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // WIDTH=4 legacy equivalence
      @(negedge clk);
      start4 = 1'b1; din4 = 4'b0110; mode4 = 2'b00; amount4 = 4'd1;
      @(posedge clk); #1; start4 = 1'b0;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (done4) begin lat = n; break; end
      end
      check("w4_latency", lat, 2);
      check("w4_dout", {28'd0, dout4}, 32'h3);
      @(posedge clk); #1;
      check("w4_done_one_cycle", {31'd0, done4}, 32'd0);
      $display("op w4 din=6 LSR amt=1 dout=%0h lat=%0d", dout4, lat);

      for (int i = 0; i < 8; i++) begin
         repeat (i % 3) @(posedge clk);
         do_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // amount=0 for every mode, then back-to-back start in the done cycle
      for (int m = 0; m < 4; m++) begin
         @(posedge clk);
         do_op(2'(m), 8'hA5, 4'd0, 8'hA5, $sformatf("amt0_m%0d", m));
      end
      do_op(2'b10, 8'h01, 4'd2, 8'h04, "back2back");

      // start pulses while busy must be ignored
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1; mode = 2'b00; din = 8'hFF; amount = 4'd8;
      @(posedge clk); #1; start = 1'b0;
      pulses = 0; lat = 0; res = 8'hxx;
      for (int n = 1; n <= 25; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            pulses++;
            if (lat == 0) begin lat = n; res = dout; end
         end
         if (n == 2 || n == 4) begin
            start = 1'b1; din = 8'h55; mode = 2'b11; amount = 4'd0;
         end
      end
      check("ignore_pulses", pulses, 1);
      check("ignore_latency", lat, 9);
      check("ignore_dout", {24'd0, res}, 32'd0);
      $display("op ignore_while_busy dout=%02h pulses=%0d lat=%0d", res, pulses, lat);

      // asynchronous reset mid-shift
      @(negedge clk);
      start = 1'b1; mode = 2'b00; din = 8'hF0; amount = 4'd10;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #3; rst_n = 1'b0;
      #1;
      check("async_rst_dout", {24'd0, dout}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("rst_no_done", pulses, 0);
      $display("op reset_mid_shift dout=%02h done_pulses_after=%0d", dout, pulses);
      do_op(2'b01, 8'h80, 4'd2, 8'hE0, "after_reset");

      // randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rm = 2'($urandom);
         rd = 8'($urandom);
         ra = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_op(rm, rd, ra, ref_shift(rm, rd, int'(ra)), $sformatf("rand%0d", i));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
